// File: rtl/filter_bank_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// filter_bank_pkg : shared types, default sizes and saturation helper
// Rev 1.0
// ----------------------------------------------------------------------------
package filter_bank_pkg;

    typedef enum logic [1:0] {
        BYP = 2'd0,
        LP  = 2'd1,
        HP  = 2'd2,
        BP  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_SH_LO    = 7;
    localparam int DEF_XF_SHIFT = 6;
    localparam int ACC_W        = DEF_DATA_W + DEF_SH_LO;
    localparam int XF_FULL      = 1 << DEF_XF_SHIFT;
    localparam int SAT_MAX_W    = 128;

    // Clamp a wide signed value into the signed range of 'width' bits.
    function automatic logic signed [SAT_MAX_W-1:0] sat_w(
        input logic signed [SAT_MAX_W-1:0] value,
        input int                          width
    );
        logic signed [SAT_MAX_W-1:0] lim_hi;
        logic signed [SAT_MAX_W-1:0] lim_lo;
        lim_hi = (SAT_MAX_W'(1) <<< (width - 1)) - SAT_MAX_W'(1);
        lim_lo = -lim_hi - SAT_MAX_W'(1);
        if (value > lim_hi) begin
            return lim_hi;
        end else if (value < lim_lo) begin
            return lim_lo;
        end
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/filter_bank_xfade_onepole_lp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// onepole_lp : combinational one-pole smoother, s' = s + ((x - s) >>> SHIFT)
// Rev 1.0
// ----------------------------------------------------------------------------
module onepole_lp #(
    parameter int ACC_W = 39,
    parameter int SHIFT = 3
) (
    input  logic signed [ACC_W-1:0] i_x,
    input  logic signed [ACC_W-1:0] i_state,
    output logic signed [ACC_W-1:0] o_state
);

    logic signed [ACC_W:0] w_diff;
    logic signed [ACC_W:0] w_step;
    logic signed [ACC_W:0] w_state_ext;

    assign w_state_ext = (ACC_W+1)'(i_state);
    assign w_diff      = (ACC_W+1)'(i_x) - w_state_ext;
    assign w_step      = w_diff >>> SHIFT;
    // The new state lies between old state and x, so it always fits ACC_W.
    assign o_state     = ACC_W'(w_state_ext + w_step);

endmodule
`default_nettype wire

// File: rtl/filter_bank_xfade.sv
`default_nettype none
// ----------------------------------------------------------------------------
// filter_bank_xfade : N-channel BYP/LP/HP/BP filter bank, one channel per clock,
//                     with linear crossfade between old and new mode
// Rev 1.0
// ----------------------------------------------------------------------------
module filter_bank_xfade
    import filter_bank_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SH_HI      = 3,
    parameter int SH_LO      = ACC_W - DEF_DATA_W,
    parameter int HP_GAIN_SH = 1,
    parameter int XF_SHIFT   = $clog2(XF_FULL)
) (
    input  logic                     AUD_BCLK,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [NUM_CH*DATA_W-1:0] sample_in,
    input  logic [1:0]               filter_choice,
    output logic                     busy,
    output logic                     out_valid,
    output logic [NUM_CH*DATA_W-1:0] sample_out,
    output logic                     overrun
);

    localparam int C_ACC_W  = DATA_W + SH_LO;
    localparam int C_XF_W   = DATA_W + XF_SHIFT + 2;
    localparam int C_CNT_W  = XF_SHIFT + 1;
    localparam int C_CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int C_FRM_W  = NUM_CH * DATA_W;

    localparam logic [C_CNT_W-1:0] C_XF_FULL = C_CNT_W'(1 << XF_SHIFT);
    localparam logic [C_CH_W-1:0]  C_LAST_CH = C_CH_W'(NUM_CH - 1);

    state_e                     r_state_q,      w_state_d;
    logic [C_CH_W-1:0]          r_ch_q,         w_ch_d;
    logic [C_FRM_W-1:0]         r_frame_in_q,   w_frame_in_d;
    logic [C_FRM_W-1:0]         r_frame_res_q,  w_frame_res_d;
    logic [C_FRM_W-1:0]         r_sample_out_q, w_sample_out_d;
    logic                       r_out_valid_q,  w_out_valid_d;
    logic                       r_busy_q,       w_busy_d;
    logic                       r_overrun_q,    w_overrun_d;
    mode_e                      r_mode_cur_q,   w_mode_cur_d;
    mode_e                      r_mode_prev_q,  w_mode_prev_d;
    logic [C_CNT_W-1:0]         r_xf_cnt_q,     w_xf_cnt_d;
    logic signed [C_ACC_W-1:0]  r_s_hi_q [NUM_CH];
    logic signed [C_ACC_W-1:0]  r_s_lo_q [NUM_CH];
    logic signed [C_ACC_W-1:0]  w_s_hi_d [NUM_CH];
    logic signed [C_ACC_W-1:0]  w_s_lo_d [NUM_CH];

    logic signed [DATA_W-1:0]    w_x;
    logic signed [C_ACC_W-1:0]   w_x_acc;
    logic signed [C_ACC_W-1:0]   w_s_hi_nxt;
    logic signed [C_ACC_W-1:0]   w_s_lo_nxt;
    logic signed [DATA_W-1:0]    w_hi_int;
    logic signed [DATA_W-1:0]    w_lo_int;
    logic signed [DATA_W:0]      w_hp_diff;
    logic signed [DATA_W:0]      w_bp_diff;
    logic signed [SAT_MAX_W-1:0] w_hp_wide;
    logic signed [DATA_W-1:0]    w_lp;
    logic signed [DATA_W-1:0]    w_hp;
    logic signed [DATA_W-1:0]    w_bp;
    logic signed [DATA_W-1:0]    w_out_a;
    logic signed [DATA_W-1:0]    w_out_b;
    logic [C_CNT_W-1:0]          w_weight;
    logic signed [C_XF_W-1:0]    w_weight_s;
    logic signed [C_XF_W-1:0]    w_xf_diff;
    logic signed [C_XF_W-1:0]    w_xf_prod;
    logic signed [C_XF_W-1:0]    w_xf_shft;
    logic signed [DATA_W-1:0]    w_y;

    // ---------------------------------------------------------------- datapath
    assign w_x     = $signed(r_frame_in_q[r_ch_q*DATA_W +: DATA_W]);
    assign w_x_acc = $signed({w_x, {SH_LO{1'b0}}});

    onepole_lp #(
        .ACC_W (C_ACC_W),
        .SHIFT (SH_HI)
    ) u_pole_hi (
        .i_x     (w_x_acc),
        .i_state (r_s_hi_q[r_ch_q]),
        .o_state (w_s_hi_nxt)
    );

    onepole_lp #(
        .ACC_W (C_ACC_W),
        .SHIFT (SH_LO)
    ) u_pole_lo (
        .i_x     (w_x_acc),
        .i_state (r_s_lo_q[r_ch_q]),
        .o_state (w_s_lo_nxt)
    );

    // Dropping the fraction bits floors toward -inf, matching >>> SH_LO.
    assign w_hi_int  = w_s_hi_nxt[C_ACC_W-1:SH_LO];
    assign w_lo_int  = w_s_lo_nxt[C_ACC_W-1:SH_LO];

    assign w_lp      = w_hi_int;
    assign w_hp_diff = (DATA_W+1)'(w_x) - (DATA_W+1)'(w_lo_int);
    assign w_hp_wide = SAT_MAX_W'(w_hp_diff) <<< HP_GAIN_SH;
    assign w_hp      = DATA_W'(sat_w(w_hp_wide, DATA_W));
    assign w_bp_diff = (DATA_W+1)'(w_hi_int) - (DATA_W+1)'(w_lo_int);
    assign w_bp      = DATA_W'(sat_w(SAT_MAX_W'(w_bp_diff), DATA_W));

    always_comb begin
        w_out_a = w_x;
        case (r_mode_prev_q)
            LP:      w_out_a = w_lp;
            HP:      w_out_a = w_hp;
            BP:      w_out_a = w_bp;
            default: w_out_a = w_x;
        endcase
    end

    always_comb begin
        w_out_b = w_x;
        case (r_mode_cur_q)
            LP:      w_out_b = w_lp;
            HP:      w_out_b = w_hp;
            BP:      w_out_b = w_bp;
            default: w_out_b = w_x;
        endcase
    end

    // Frame k after a change uses weight k; xf_cnt only advances in DONE.
    assign w_weight   = (r_xf_cnt_q == C_XF_FULL) ? C_XF_FULL : (r_xf_cnt_q + C_CNT_W'(1));
    assign w_weight_s = $signed({{(C_XF_W-C_CNT_W){1'b0}}, w_weight});
    assign w_xf_diff  = C_XF_W'(w_out_b) - C_XF_W'(w_out_a);
    assign w_xf_prod  = w_xf_diff * w_weight_s;
    assign w_xf_shft  = w_xf_prod >>> XF_SHIFT;
    assign w_y        = DATA_W'(sat_w(SAT_MAX_W'(w_xf_shft) + SAT_MAX_W'(w_out_a), DATA_W));

    // ---------------------------------------------------------------- control
    always_comb begin
        w_state_d      = r_state_q;
        w_ch_d         = r_ch_q;
        w_frame_in_d   = r_frame_in_q;
        w_frame_res_d  = r_frame_res_q;
        w_sample_out_d = r_sample_out_q;
        w_out_valid_d  = 1'b0;
        w_busy_d       = r_busy_q;
        w_overrun_d    = in_valid && (r_state_q != ST_IDLE);
        w_mode_cur_d   = r_mode_cur_q;
        w_mode_prev_d  = r_mode_prev_q;
        w_xf_cnt_d     = r_xf_cnt_q;
        w_s_hi_d       = r_s_hi_q;
        w_s_lo_d       = r_s_lo_q;

        case (r_state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    w_frame_in_d = sample_in;
                    w_busy_d     = 1'b1;
                    w_ch_d       = '0;
                    w_state_d    = ST_RUN;
                    if ((r_xf_cnt_q == C_XF_FULL) && (filter_choice != r_mode_cur_q)) begin
                        w_mode_prev_d = r_mode_cur_q;
                        w_mode_cur_d  = mode_e'(filter_choice);
                        w_xf_cnt_d    = '0;
                    end
                end
            end
            ST_RUN: begin
                w_s_hi_d[r_ch_q] = w_s_hi_nxt;
                w_s_lo_d[r_ch_q] = w_s_lo_nxt;
                w_frame_res_d[r_ch_q*DATA_W +: DATA_W] = w_y;
                if (r_ch_q == C_LAST_CH) begin
                    w_state_d      = ST_DONE;
                    w_out_valid_d  = 1'b1;
                    w_busy_d       = 1'b0;
                    w_sample_out_d = w_frame_res_d;
                end else begin
                    w_ch_d = r_ch_q + C_CH_W'(1);
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
                if (r_xf_cnt_q < C_XF_FULL) begin
                    w_xf_cnt_d = r_xf_cnt_q + C_CNT_W'(1);
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge AUD_BCLK) begin
        if (reset) begin
            r_state_q      <= ST_IDLE;
            r_ch_q         <= '0;
            r_frame_in_q   <= '0;
            r_frame_res_q  <= '0;
            r_sample_out_q <= '0;
            r_out_valid_q  <= 1'b0;
            r_busy_q       <= 1'b0;
            r_overrun_q    <= 1'b0;
            r_mode_cur_q   <= BYP;
            r_mode_prev_q  <= BYP;
            r_xf_cnt_q     <= C_XF_FULL;
            r_s_hi_q       <= '{default: '0};
            r_s_lo_q       <= '{default: '0};
        end else begin
            r_state_q      <= w_state_d;
            r_ch_q         <= w_ch_d;
            r_frame_in_q   <= w_frame_in_d;
            r_frame_res_q  <= w_frame_res_d;
            r_sample_out_q <= w_sample_out_d;
            r_out_valid_q  <= w_out_valid_d;
            r_busy_q       <= w_busy_d;
            r_overrun_q    <= w_overrun_d;
            r_mode_cur_q   <= w_mode_cur_d;
            r_mode_prev_q  <= w_mode_prev_d;
            r_xf_cnt_q     <= w_xf_cnt_d;
            r_s_hi_q       <= w_s_hi_d;
            r_s_lo_q       <= w_s_lo_d;
        end
    end

    assign busy       = r_busy_q;
    assign out_valid  = r_out_valid_q;
    assign sample_out = r_sample_out_q;
    assign overrun    = r_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_filter_bank_xfade.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_filter_bank_xfade : directed bench, one DUT with immediate switching and
//                        one with a 4-frame crossfade, driven in lockstep
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_filter_bank_xfade;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] sample_in;
    logic [1:0]  filter_choice;

    logic        busy0, ov0, orun0;
    logic [63:0] out0;
    logic        busy2, ov2, orun2;
    logic [63:0] out2;

    logic [63:0]        r0, r2;
    logic signed [31:0] y, prev, first;
    int                 n_tests = 0;
    int                 n_fail  = 0;
    int                 pulses;

    always #5 clk = ~clk;

    filter_bank_xfade #(
        .NUM_CH(2), .DATA_W(32), .SH_HI(3), .SH_LO(7), .HP_GAIN_SH(1), .XF_SHIFT(0)
    ) dut0 (
        .AUD_BCLK(clk), .reset(rst), .in_valid(in_valid), .sample_in(sample_in),
        .filter_choice(filter_choice), .busy(busy0), .out_valid(ov0),
        .sample_out(out0), .overrun(orun0)
    );

    filter_bank_xfade #(
        .NUM_CH(2), .DATA_W(32), .SH_HI(3), .SH_LO(7), .HP_GAIN_SH(1), .XF_SHIFT(2)
    ) dut2 (
        .AUD_BCLK(clk), .reset(rst), .in_valid(in_valid), .sample_in(sample_in),
        .filter_choice(filter_choice), .busy(busy2), .out_valid(ov2),
        .sample_out(out2), .overrun(orun2)
    );

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (%h) expected %0d (%h)", tag,
                   $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One full frame: strobe, wait (bounded) for out_valid, then step past DONE.
    task automatic frame(input logic [31:0] c0, input logic [31:0] c1, input logic [1:0] m);
        int k;
        sample_in     = {c1, c0};
        filter_choice = m;
        in_valid      = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!ov0 && k < 8) begin
            tick();
            k++;
        end
        if (!ov0) check32("frame_timeout", 32'd0, 32'd1);
        r0 = out0;
        r2 = out2;
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        sample_in     = '0;
        filter_choice = 2'd0;

        // Reset state and bypass latency
        do_reset();
        check64("rst_out",     out0, 64'd0);
        check32("rst_valid",   {31'd0, ov0}, 32'd0);
        check32("rst_busy",    {31'd0, busy0}, 32'd0);
        check32("rst_overrun", {31'd0, orun0}, 32'd0);
        sample_in = {32'hFFFF_FFFB, 32'd1234};
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        check32("lat_c1_busy",  {31'd0, busy0}, 32'd1);
        check32("lat_c1_valid", {31'd0, ov0}, 32'd0);
        tick();
        check32("lat_c2_busy",  {31'd0, busy0}, 32'd1);
        check32("lat_c2_valid", {31'd0, ov0}, 32'd0);
        tick();
        check32("lat_c3_valid", {31'd0, ov0}, 32'd1);
        check32("lat_c3_busy",  {31'd0, busy0}, 32'd0);
        check64("byp_frame",    out0, 64'hFFFF_FFFB_0000_04D2);
        check64("byp_frame_x2", out2, 64'hFFFF_FFFB_0000_04D2);
        tick();
        check32("lat_c4_valid", {31'd0, ov0}, 32'd0);

        // Overrun on cycle 1 of a frame
        sample_in = {32'hFFFF_FFF7, 32'd7};
        in_valid  = 1'b1;
        tick();
        check32("ovr_c1", {31'd0, orun0}, 32'd0);
        sample_in = {32'd200, 32'd100};
        tick();
        in_valid = 1'b0;
        check32("ovr_pulse", {31'd0, orun0}, 32'd1);
        tick();
        check32("ovr_valid", {31'd0, ov0}, 32'd1);
        check32("ovr_clear", {31'd0, orun0}, 32'd0);
        check64("ovr_data",  out0, 64'hFFFF_FFF7_0000_0007);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (ov0) pulses++;
        end
        check32("ovr_no_extra", pulses, 32'd0);

        // LP step response with immediate switching
        do_reset();
        prev = 0;
        for (int f = 0; f < 200; f++) begin
            frame(32'd1048576, 32'd1048576, 2'd1);
            y = r0[31:0];
            if (f == 0) check32("lp_first", y, 32'd131072);
            check32("lp_mono", {31'd0, (y >= prev) && (y <= 32'sd1048576)}, 32'd1);
            prev = y;
        end
        check32("lp_settle", {31'd0, y >= 32'sd1048575}, 32'd1);
        check32("lp_ch1",    r0[63:32], r0[31:0]);

        // HP step response decays toward zero
        do_reset();
        prev  = 32'sh7FFF_FFFF;
        first = 0;
        for (int f = 0; f < 200; f++) begin
            frame(32'd1048576, 32'd1048576, 2'd2);
            y = r0[31:0];
            if (f == 0) begin
                check32("hp_first", y, 32'd2080768);
                first = y;
            end
            check32("hp_decay", {31'd0, (y <= prev) && (y >= 0)}, 32'd1);
            prev = y;
        end
        check32("hp_lower", {31'd0, y < (first >>> 1)}, 32'd1);

        // HP saturation, both directions
        do_reset();
        frame(32'h8000_0000, 32'h8000_0000, 2'd2);
        check32("hp_sat_neg", r0[31:0], 32'h8000_0000);
        for (int f = 0; f < 10; f++) frame(32'h8000_0000, 32'h8000_0000, 2'd2);
        frame(32'h7FFF_FFFF, 32'h7FFF_FFFF, 2'd2);
        check32("hp_sat_pos0", r0[31:0],  32'h7FFF_FFFF);
        check32("hp_sat_pos1", r0[63:32], 32'h7FFF_FFFF);

        // Crossfade BYP->BP over 4 frames, second request deferred to frame 5
        do_reset();
        frame(32'd4000, 32'd4000, 2'd3);
        check32("xf_f1",     r2[31:0],  32'd3117);
        check32("xf_f1_ch1", r2[63:32], 32'd3117);
        check32("xf_imm_f1", r0[31:0],  32'd469);
        frame(32'd4000, 32'd4000, 2'd2);
        check32("xf_f2", r2[31:0], 32'd2437);
        frame(32'd4000, 32'd4000, 2'd2);
        check32("xf_f3", r2[31:0], 32'd1920);
        frame(32'd4000, 32'd4000, 2'd2);
        check32("xf_f4", r2[31:0], 32'd1532);
        frame(32'd4000, 32'd4000, 2'd2);
        check32("xf_f5", r2[31:0], 32'd3269);

        // Reset mid-RUN aborts the frame and clears filter state
        do_reset();
        for (int f = 0; f < 3; f++) frame(32'd1048576, 32'd1048576, 2'd1);
        sample_in     = {32'd5, 32'd5};
        filter_choice = 2'd1;
        in_valid      = 1'b1;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check32("mid_rst_busy",  {31'd0, busy0}, 32'd0);
        check32("mid_rst_valid", {31'd0, ov0}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (ov0) pulses++;
        end
        check32("mid_rst_no_valid", pulses, 32'd0);
        frame(32'd1048576, 32'd1048576, 2'd1);
        check32("mid_rst_lp0", r0[31:0],  32'd131072);
        check32("mid_rst_lp1", r0[63:32], 32'd131072);
        frame(32'hFFFF_FFB3, 32'd999, 2'd0);
        check64("mid_rst_byp", r0, {32'd999, 32'hFFFF_FFB3});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
